// File: rtl/pc_unit.sv
// Program-counter unit for the MZNM fetch stage.
// Adds stall, a circular return-address stack and single-level interrupts.
module pc_unit #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = 'h20,
  parameter int unsigned     INC       = 2,
  parameter logic [PC_W-1:0] INT_VEC   = 'h10,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       pc_src,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       rti,
  input  logic [PC_W-1:0]            target,
  input  logic                       intr_req,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            epc,
  output logic                       int_en,
  output logic                       intr_ack,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_err
);

  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam logic [CW-1:0] EMPTY = '0;
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] epc_q;
  logic [PC_W-1:0] epc_d;
  logic            int_en_q;
  logic            int_en_d;
  logic            ack_q;
  logic            ack_d;
  logic            err_q;
  logic            err_d;
  logic [AW-1:0]   sp_q;
  logic [AW-1:0]   sp_d;
  logic [AW-1:0]   top_idx;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            push;
  logic [PC_W-1:0] seq_pc;
  logic            take_int;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];

  assign seq_pc   = pc_q + INC_V;
  assign top_idx  = sp_q - AW'(1);
  assign take_int = intr_req & int_en_q & ~pc_src & ~ret & ~rti;

  // sp_q is the next free slot; pushes past full wrap onto the oldest entry
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    int_en_d = int_en_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    if (!stall) begin
      priority case (1'b1)
        take_int: begin
          epc_d    = seq_pc;
          pc_d     = INT_VEC;
          int_en_d = 1'b0;
          ack_d    = 1'b1;
        end
        rti: begin
          pc_d     = epc_q;
          int_en_d = 1'b1;
        end
        pc_src: begin
          pc_d = target;
          if (call) begin
            push = 1'b1;
            sp_d = sp_q + AW'(1);
            if (cnt_q == FULL) begin
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ret: begin
          if (cnt_q == EMPTY) begin
            pc_d  = seq_pc;
            err_d = 1'b1;
          end else begin
            pc_d  = ras_q[top_idx];
            sp_d  = top_idx;
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      int_en_q <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      sp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      int_en_q <= int_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ras_q[sp_q] <= seq_pc;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign int_en    = int_en_q;
  assign intr_ack  = ack_q;
  assign ras_count = cnt_q;
  assign ras_err   = err_q;

endmodule
